// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state and request types for the multi-cycle RV32I ALU.
package alu_pkg;

  localparam int ALU_XLEN    = 32;
  localparam int ALU_SHAMT_W = 5;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} alu_state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} sh_kind_t;

  typedef struct packed {
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [ALU_XLEN-1:0] rs1;
    logic [ALU_XLEN-1:0] rs2;
  } alu_req_t;

  // funct7=0x20 is only meaningful for SUB and SRA
  function automatic logic op_legal(input logic [2:0] f3, input logic [6:0] f7);
    return (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
  endfunction

  function automatic logic op_is_shift(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SR);
  endfunction

  function automatic sh_kind_t shift_kind(input logic [2:0] f3, input logic [6:0] f7);
    if (f3 == F3_SLL)      return SH_LL;
    else if (f7 == F7_ALT) return SH_RA;
    else                   return SH_RL;
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Shift datapath: iterative one-bit-per-cycle shifter with shamt down-counter, or a
// single-cycle barrel shifter on latched operands when ALU_BARREL_SHIFT_EN is defined.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = ALU_XLEN,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  sh_kind_t           kind,
  input  logic [XLEN-1:0]    data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [XLEN-1:0]    result,
  output logic               done
);

  sh_kind_t           kind_q;
  logic [XLEN-1:0]    sh_q;
  logic [SHAMT_W-1:0] cnt_q;

`ifdef ALU_BARREL_SHIFT_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      kind_q <= SH_LL;
      sh_q   <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      kind_q <= kind;
      sh_q   <= data;
      cnt_q  <= shamt;
    end
  end

  always_comb begin
    result = sh_q >> cnt_q;
    case (kind_q)
      SH_LL:   result = sh_q << cnt_q;
      SH_RA:   result = $signed(sh_q) >>> cnt_q;
      default: result = sh_q >> cnt_q;
    endcase
  end

  assign done = 1'b1;
`else
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      kind_q <= SH_LL;
      sh_q   <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      kind_q <= kind;
      sh_q   <= data;
      cnt_q  <= shamt;
    end else if (cnt_q != '0) begin
      case (kind_q)
        SH_LL:   sh_q <= {sh_q[XLEN-2:0], 1'b0};
        SH_RA:   sh_q <= {sh_q[XLEN-1], sh_q[XLEN-1:1]};
        default: sh_q <= {1'b0, sh_q[XLEN-1:1]};
      endcase
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign result = sh_q;
  assign done   = (cnt_q == '0);
`endif

endmodule

// File: rtl/alu_seq_responder.sv
// Multi-cycle RV32I ALU behind valid/ready request and result handshakes.
// ALU_BARREL_SHIFT_EN selects single-cycle shifts; default is the iterative shifter.
module alu_seq_responder
  import alu_pkg::*;
#(
  parameter int XLEN    = ALU_XLEN,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] register_data_1,
  input  logic [XLEN-1:0] register_data_2,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] register_data_out,
  output logic            illegal_op
);

  alu_state_t      state_q, state_d;
  alu_req_t        req_in, req_q;
  logic            accept, go_shift, sh_done, ill_q;
  logic [XLEN-1:0] sh_result, exec_res, out_q;

  assign req_in = '{funct3: funct3, funct7: funct7, rs1: register_data_1, rs2: register_data_2};

`ifdef ALU_BARREL_SHIFT_EN
  assign go_shift = 1'b0;
`else
  assign go_shift = op_legal(funct3, funct7) && op_is_shift(funct3);
`endif

  // shift unit captures its operands straight from the ports on accept
  alu_shift_unit #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shift (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (accept),
    .kind    (shift_kind(funct3, funct7)),
    .data    (register_data_1),
    .shamt   (register_data_2[SHAMT_W-1:0]),
    .result  (sh_result),
    .done    (sh_done)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = go_shift ? SHIFT : EXEC;
      EXEC:    state_d = DONE;
      SHIFT:   if (sh_done) state_d = DONE;
      DONE:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_ready     = (state_q == IDLE);
    result_valid = (state_q == DONE);
    accept       = op_valid && op_ready;
  end

  always_comb begin
    exec_res = '0;
    if (op_legal(req_q.funct3, req_q.funct7)) begin
      case (req_q.funct3)
        F3_ADD:  exec_res = (req_q.funct7 == F7_ALT) ? req_q.rs1 - req_q.rs2 : req_q.rs1 + req_q.rs2;
        F3_SLT:  exec_res = {{(XLEN-1){1'b0}}, $signed(req_q.rs1) < $signed(req_q.rs2)};
        F3_SLTU: exec_res = {{(XLEN-1){1'b0}}, req_q.rs1 < req_q.rs2};
        F3_XOR:  exec_res = req_q.rs1 ^ req_q.rs2;
        F3_OR:   exec_res = req_q.rs1 | req_q.rs2;
        F3_AND:  exec_res = req_q.rs1 & req_q.rs2;
        default: exec_res = sh_result;  // barrel build only; iterative shifts never reach EXEC
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      req_q <= '0;
      out_q <= '0;
      ill_q <= 1'b0;
    end else begin
      if (accept) req_q <= req_in;
      if (state_q == EXEC) begin
        out_q <= exec_res;
        ill_q <= !op_legal(req_q.funct3, req_q.funct7);
      end else if ((state_q == SHIFT) && sh_done) begin
        out_q <= sh_result;
        ill_q <= 1'b0;
      end
    end
  end

  assign register_data_out = out_q;
  assign illegal_op        = ill_q;

endmodule

// File: tb/tb_alu_seq_responder.sv
// Bench for alu_seq_responder: transaction-level model checked every cycle plus literal vectors.
module tb_alu_seq_responder;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n, op_valid, op_ready, result_valid, result_ready, illegal_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] register_data_1, register_data_2, register_data_out;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  alu_seq_responder dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .op_valid          (op_valid),
    .op_ready          (op_ready),
    .funct3            (funct3),
    .funct7            (funct7),
    .register_data_1   (register_data_1),
    .register_data_2   (register_data_2),
    .result_valid      (result_valid),
    .result_ready      (result_ready),
    .register_data_out (register_data_out),
    .illegal_op        (illegal_op)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: what the operation means, and how long it must take
  task automatic ref_alu(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output bit ill, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    ill = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    lat = 2;
    r   = 32'd0;
    if (!ill) begin
      case (f3)
        3'd0: r = (f7 == 7'h20) ? a - b : a + b;
        3'd1: r = a << sh;
        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = (f7 == 7'h20) ? 32'($signed(a) >>> sh) : a >> sh;
        3'd6: r = a | b;
        default: r = a & b;
      endcase
      if (!BARREL && (f3 == 3'd1 || f3 == 3'd5)) lat = 2 + sh;
    end
  endtask

  // model: busy from accept until result handshake; result appears lat cycles after accept
  bit          m_busy = 1'b0, m_rv = 1'b0, m_ill = 1'b0;
  int          m_cnt = 0, m_done = 0;
  logic [31:0] m_res = '0;

  always @(posedge clock) begin
    int lat;
    if (!reset_n) begin
      m_busy = 1'b0;
      m_rv   = 1'b0;
    end else if (m_rv) begin
      if (result_ready) begin
        m_rv   = 1'b0;
        m_busy = 1'b0;
        m_done++;
      end
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) m_rv = 1'b1;
    end else if (op_valid) begin
      ref_alu(funct3, funct7, register_data_1, register_data_2, m_res, m_ill, lat);
      m_cnt  = lat - 1;
      m_busy = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("op_ready", {31'd0, op_ready}, {31'd0, !m_busy});
      chk("result_valid", {31'd0, result_valid}, {31'd0, m_rv});
      if (m_rv) begin
        chk("model_out", register_data_out, m_res);
        chk("model_ill", {31'd0, illegal_op}, {31'd0, m_ill});
      end
    end
  end

  // one operation from idle, literal expectations on value, flag and latency
  task automatic do_op(input string nm, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit exp_ill, input int exp_lat);
    int n;
    @(posedge clock); #2;
    op_valid = 1'b1; funct3 = f3; funct7 = f7;
    register_data_1 = a; register_data_2 = b; result_ready = 1'b1;
    @(posedge clock); #2;
    op_valid = 1'b0;
    register_data_1 = $urandom; register_data_2 = $urandom;
    funct3 = 3'($urandom); funct7 = 7'($urandom);
    n = 0;
    do begin @(negedge clock); n++; end while (!result_valid && n < 100);
    chk({nm, "_lat"}, n, exp_lat);
    chk({nm, "_out"}, register_data_out, exp);
    chk({nm, "_ill"}, {31'd0, illegal_op}, {31'd0, exp_ill});
  endtask

  // called at posedge+2; holds op_valid until accepted
  task automatic issue(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    int n;
    op_valid = 1'b1; funct3 = f3; funct7 = f7;
    register_data_1 = a; register_data_2 = b;
    n = 0;
    do begin @(negedge clock); n++; end while (!op_ready && n < 100);
    if (n >= 100) chk("issue_timeout", 32'd0, 32'd1);
    @(posedge clock); #2;
    op_valid = 1'b0;
  endtask

  initial begin
    int n, issued;
    logic [31:0] held;
    reset_n = 1'b0; op_valid = 1'b0; result_ready = 1'b0;
    funct3 = '0; funct7 = '0; register_data_1 = '0; register_data_2 = '0;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_out", register_data_out, 32'd0);
    chk("rst_ill", {31'd0, illegal_op}, 32'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    do_op("add",      3'd0, 7'h00, 32'd1,        32'd2,        32'h00000003, 1'b0, 2);
    do_op("sub_wrap", 3'd0, 7'h20, 32'd1,        32'd2,        32'hFFFFFFFF, 1'b0, 2);
    do_op("slt",      3'd2, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 2);
    do_op("sltu",     3'd3, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 2);
    do_op("sra4",     3'd5, 7'h20, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, BARREL ? 2 : 6);
    do_op("sll0",     3'd1, 7'h00, 32'h00001234, 32'd0,        32'h00001234, 1'b0, 2);
    do_op("srl31",    3'd5, 7'h00, 32'h80000000, 32'd31,       32'd1,        1'b0, BARREL ? 2 : 33);
    do_op("sll31",    3'd1, 7'h00, 32'd3,        32'hFFFFFFFF, 32'h80000000, 1'b0, BARREL ? 2 : 33);
    do_op("xor",      3'd4, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 2);
    do_op("and",      3'd7, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 2);
    do_op("ill_or",   3'd6, 7'h20, 32'h000000F0, 32'h0000000F, 32'd0,        1'b1, 2);
    do_op("ill_add",  3'd0, 7'h01, 32'd5,        32'd6,        32'd0,        1'b1, 2);

    // backpressure: result held, new request refused until after the handshake
    @(posedge clock); #2;
    op_valid = 1'b1; funct3 = 3'd5; funct7 = 7'h20;
    register_data_1 = 32'h80000000; register_data_2 = 32'd4; result_ready = 1'b0;
    @(posedge clock); #2;
    op_valid = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!result_valid && n < 100);
    chk("bp_lat", n, BARREL ? 2 : 6);
    held = register_data_out;
    chk("bp_out", held, 32'hF8000000);
    op_valid = 1'b1; funct3 = 3'd0; funct7 = 7'h00;
    register_data_1 = 32'd5; register_data_2 = 32'd6;
    repeat (5) begin
      @(negedge clock);
      chk("bp_hold_out", register_data_out, held);
      chk("bp_hold_valid", {31'd0, result_valid}, 32'd1);
      chk("bp_hold_ready", {31'd0, op_ready}, 32'd0);
    end
    result_ready = 1'b1;
    @(posedge clock); #2;
    chk("bp_ready_after", {31'd0, op_ready}, 32'd1);
    @(posedge clock); #2;
    op_valid = 1'b0;
    chk("bp_accepted", {31'd0, op_ready}, 32'd0);
    n = 0;
    do begin @(negedge clock); n++; end while (!result_valid && n < 100);
    chk("bp_next_lat", n, 2);
    chk("bp_next_out", register_data_out, 32'd11);

    // reset during a long shift aborts it
    @(posedge clock); #2;
    op_valid = 1'b1; funct3 = 3'd1; funct7 = 7'h00;
    register_data_1 = 32'd1; register_data_2 = 32'd20;
    @(posedge clock); #2;
    op_valid = 1'b0;
    if (!BARREL) begin
      repeat (5) @(posedge clock);
      #2;
    end
    reset_n = 1'b0;
    @(posedge clock); #2;
    reset_n = 1'b1;
    @(negedge clock);
    chk("abort_valid", {31'd0, result_valid}, 32'd0);
    chk("abort_ready", {31'd0, op_ready}, 32'd1);
    repeat (25) @(posedge clock);
    chk("abort_no_result", {31'd0, result_valid}, 32'd0);

    // back-to-back sweep, checked by the model
    @(posedge clock); #2;
    result_ready = 1'b1;
    issued = m_done;
    for (int i = 1; i <= 10; i++) begin
      issue(3'd0, 7'h00, 32'd1, 32'(i));
      issue(3'd0, 7'h20, 32'd1, 32'(i));
      issue(3'd5, 7'h20, 32'hF0000000, 32'(i));
    end
    repeat (20) @(posedge clock);
    chk("sweep_count", 32'(m_done - issued), 32'd30);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
